// File: rtl/soc_system_pio_status_irq_if.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_status_irq_if
// Purpose  : Avalon-MM slave bus bundle for the status PIO with interrupt.
//            The master drives address/chipselect/write_n/writedata; the
//            slave returns registered readdata (read latency 1).
// Signals  : address    [1:0]  register select
//            chipselect        slave select
//            write_n           active-low write strobe
//            writedata  [31:0] write data
//            readdata   [31:0] registered read data
// Revision : 1.0  initial release
// ============================================================================
interface soc_system_pio_status_irq_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface
`default_nettype wire

// File: rtl/soc_system_pio_status_irq.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_status_irq
// Purpose  : Status input PIO with edge capture, per-bit interrupt mask,
//            level interrupt and a change-event counter, on an Avalon-MM
//            slave (read latency 1).
// Register map:
//            0 DATA    (RO)   sampled input, zero-extended
//            1 CHGCNT  (RW)   cycles with any input change; any write clears
//            2 IRQMASK (RW)   per-bit interrupt enable
//            3 EDGECAP (W1C)  captured edges; set wins over clear
// Ports    : clk      in   system clock (rising edge)
//            reset_n  in   asynchronous active-low reset
//            bus      slave Avalon-MM bundle (soc_system_pio_status_irq_if)
//            in_port  in   status inputs [DATA_WIDTH-1:0]
//            irq      out  |(EDGECAP & IRQMASK)
// Config   : PIO_STATUS_SYNC_EN defined   -> 2-flop synchronizer on in_port
//            PIO_STATUS_SYNC_EN undefined -> single sampling flop
// Revision : 1.0  initial release
// ============================================================================
module soc_system_pio_status_irq #(
   parameter int DATA_WIDTH = 32,
   parameter int EDGE_TYPE  = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  wire logic                  clk,
   input  wire logic                  reset_n,
   soc_system_pio_status_irq_if.slave bus,
   input  wire logic [DATA_WIDTH-1:0] in_port,
   output logic                       irq
);

   localparam logic [1:0] c_ADDR_DATA    = 2'd0;
   localparam logic [1:0] c_ADDR_CHGCNT  = 2'd1;
   localparam logic [1:0] c_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] c_ADDR_EDGECAP = 2'd3;

`ifdef PIO_STATUS_SYNC_EN
   logic [DATA_WIDTH-1:0] s1_q;
`endif
   logic [DATA_WIDTH-1:0] s2_q;
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
   logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
   logic [CNT_WIDTH-1:0]  chgcnt_q,  chgcnt_d;
   logic [31:0]           readdata_q, readdata_d;

   logic [DATA_WIDTH-1:0] w_edge;
   logic                  w_change;
   logic                  w_wr;
   logic                  w_unused_wdata;

   // Upper writedata bits have no destination when DATA_WIDTH < 32.
   assign w_unused_wdata = &{1'b0, bus.writedata, 1'b0};

   assign w_wr     = bus.chipselect & ~bus.write_n;
   assign w_change = |(s2_q ^ prev_q);

   // Edge term selected at elaboration time.
   generate
      if (EDGE_TYPE == 1) begin : g_edge_fall
         assign w_edge = ~s2_q & prev_q;
      end else if (EDGE_TYPE == 2) begin : g_edge_any
         assign w_edge = s2_q ^ prev_q;
      end else begin : g_edge_rise
         assign w_edge = s2_q & ~prev_q;
      end
   endgenerate

   always_comb begin
      edgecap_d  = edgecap_q;
      irqmask_d  = irqmask_q;
      chgcnt_d   = chgcnt_q;
      readdata_d = '0;

      // W1C first, then OR in new edges so a same-cycle set wins.
      if (w_wr && (bus.address == c_ADDR_EDGECAP)) begin
         edgecap_d = edgecap_q & ~bus.writedata[DATA_WIDTH-1:0];
      end
      edgecap_d = edgecap_d | w_edge;

      if (w_wr && (bus.address == c_ADDR_IRQMASK)) begin
         irqmask_d = bus.writedata[DATA_WIDTH-1:0];
      end

      // A clear coinciding with a change leaves the count at 1.
      if (w_wr && (bus.address == c_ADDR_CHGCNT)) begin
         chgcnt_d = w_change ? CNT_WIDTH'(1) : '0;
      end else if (w_change) begin
         chgcnt_d = chgcnt_q + CNT_WIDTH'(1);
      end

      // Read mux is sampled every cycle regardless of chipselect.
      case (bus.address)
         c_ADDR_DATA:    readdata_d[DATA_WIDTH-1:0] = s2_q;
         c_ADDR_CHGCNT:  readdata_d[CNT_WIDTH-1:0]  = chgcnt_q;
         c_ADDR_IRQMASK: readdata_d[DATA_WIDTH-1:0] = irqmask_q;
         default:        readdata_d[DATA_WIDTH-1:0] = edgecap_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
`ifdef PIO_STATUS_SYNC_EN
         s1_q       <= '0;
`endif
         s2_q       <= '0;
         prev_q     <= '0;
         edgecap_q  <= '0;
         irqmask_q  <= '0;
         chgcnt_q   <= '0;
         readdata_q <= '0;
      end else begin
`ifdef PIO_STATUS_SYNC_EN
         s1_q       <= in_port;
         s2_q       <= s1_q;
`else
         s2_q       <= in_port;
`endif
         prev_q     <= s2_q;
         edgecap_q  <= edgecap_d;
         irqmask_q  <= irqmask_d;
         chgcnt_q   <= chgcnt_d;
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;

   // Driven from registers only, so no combinational glitches reach irq.
   assign irq = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_status_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_pio_status_irq
// Purpose  : Self-checking bench for soc_system_pio_status_irq. Three
//            instances (rising, falling, any-edge; 8-bit data, 4-bit
//            counter) share one bus and one input vector and are compared
//            every cycle against a behavioural model, plus directed checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_soc_system_pio_status_irq;

`ifdef PIO_STATUS_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        cs = 1'b0;
   logic        wn = 1'b1;
   logic [31:0] wdata = '0;
   logic [7:0]  in_port = 8'h00;

   logic [31:0] rd  [3];
   logic        irq [3];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   soc_system_pio_status_irq_if bus_r ();
   soc_system_pio_status_irq_if bus_f ();
   soc_system_pio_status_irq_if bus_a ();

   assign bus_r.address = address; assign bus_r.chipselect = cs;
   assign bus_r.write_n = wn;      assign bus_r.writedata  = wdata;
   assign bus_f.address = address; assign bus_f.chipselect = cs;
   assign bus_f.write_n = wn;      assign bus_f.writedata  = wdata;
   assign bus_a.address = address; assign bus_a.chipselect = cs;
   assign bus_a.write_n = wn;      assign bus_a.writedata  = wdata;
   assign rd[0] = bus_r.readdata;
   assign rd[1] = bus_f.readdata;
   assign rd[2] = bus_a.readdata;

   soc_system_pio_status_irq #(.DATA_WIDTH(8), .EDGE_TYPE(0), .CNT_WIDTH(4)) u_rise (
      .clk(clk), .reset_n(rst_n), .bus(bus_r), .in_port(in_port), .irq(irq[0]));
   soc_system_pio_status_irq #(.DATA_WIDTH(8), .EDGE_TYPE(1), .CNT_WIDTH(4)) u_fall (
      .clk(clk), .reset_n(rst_n), .bus(bus_f), .in_port(in_port), .irq(irq[1]));
   soc_system_pio_status_irq #(.DATA_WIDTH(8), .EDGE_TYPE(2), .CNT_WIDTH(4)) u_any (
      .clk(clk), .reset_n(rst_n), .bus(bus_a), .in_port(in_port), .irq(irq[2]));

   // ---------------- behavioural reference model ----------------
   // Sampled-value history: m_hist[0] is the newest sampled value (DATA),
   // m_hist[1] the one before it. m_pipe holds inputs still in flight.
   logic [7:0] m_pipe;
   logic [7:0] m_hist [2];
   logic [7:0] m_cap  [3];
   logic [7:0] m_mask;
   int         m_cnt;
   logic [31:0] m_rd  [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pipe = '0; m_hist[0] = '0; m_hist[1] = '0; m_mask = '0; m_cnt = 0;
         for (int e = 0; e < 3; e++) begin m_cap[e] = '0; m_rd[e] = '0; end
      end else begin
         logic [7:0] cur, old;
         logic       wr, moved;
         cur   = m_hist[0];
         old   = m_hist[1];
         wr    = cs && !wn;
         moved = (cur != old);
         for (int e = 0; e < 3; e++) begin
            case (address)
               2'd0: m_rd[e] = {24'd0, cur};
               2'd1: m_rd[e] = 32'(m_cnt);
               2'd2: m_rd[e] = {24'd0, m_mask};
               default: m_rd[e] = {24'd0, m_cap[e]};
            endcase
            if (wr && address == 2'd3) m_cap[e] = m_cap[e] & ~wdata[7:0];
            for (int b = 0; b < 8; b++) begin
               bit went_up, went_down;
               went_up   = (old[b] == 1'b0) && (cur[b] == 1'b1);
               went_down = (old[b] == 1'b1) && (cur[b] == 1'b0);
               if ((e == 0 && went_up) || (e == 1 && went_down) ||
                   (e == 2 && (went_up || went_down)))
                  m_cap[e][b] = 1'b1;
            end
         end
         if (wr && address == 2'd2) m_mask = wdata[7:0];
         if (wr && address == 2'd1) m_cnt = moved ? 1 : 0;
         else if (moved)            m_cnt = (m_cnt + 1) % 16;
         m_hist[1] = cur;
         if (LAT == 2) begin
            m_hist[0] = m_pipe;
            m_pipe    = in_port;
         end else begin
            m_hist[0] = in_port;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int e = 0; e < 3; e++) begin
         chk($sformatf("model_rd[%0d]", e), rd[e], m_rd[e]);
         chk($sformatf("model_irq[%0d]", e), 32'(irq[e]), 32'(|(m_cap[e] & m_mask)));
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; wdata = d; cs = 1'b1; wn = 1'b0;
      tick();
      cs = 1'b0; wn = 1'b1;
   endtask

   task automatic rd_addr(input logic [1:0] a);
      address = a;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset / idle
      for (int a = 0; a < 4; a++) begin
         rd_addr(2'(a));
         for (int e = 0; e < 3; e++) chk($sformatf("reset_rd a%0d d%0d", a, e), rd[e], 32'h0);
      end
      for (int e = 0; e < 3; e++) chk("reset_irq", 32'(irq[e]), 32'h0);

      // Rising capture with exact irq latency
      wr(2'd2, 32'h01);
      in_port = 8'h81;
      for (int i = 1; i <= LAT + 1; i++) begin
         tick();
         chk($sformatf("irq_latency t%0d", i), 32'(irq[0]), (i == LAT + 1) ? 32'h1 : 32'h0);
      end
      rd_addr(2'd3);
      chk("rise_cap", rd[0], 32'h81);
      chk("fall_cap_none", rd[1], 32'h00);
      chk("any_cap", rd[2], 32'h81);
      rd_addr(2'd0);
      chk("data", rd[0], 32'h81);
      rd_addr(2'd1);
      chk("chgcnt_one", rd[0], 32'h1);

      // W1C and mask
      wr(2'd3, 32'h80);
      rd_addr(2'd3);
      chk("w1c_partial", rd[0], 32'h01);
      chk("w1c_irq_held", 32'(irq[0]), 32'h1);
      wr(2'd3, 32'h01);
      chk("w1c_irq_low", 32'(irq[0]), 32'h0);
      rd_addr(2'd3);
      chk("w1c_all", rd[0], 32'h00);

      // Falling edge on bit 0, then set/clear collision on a rising edge
      in_port = 8'h80;
      repeat (LAT + 2) tick();
      rd_addr(2'd3);
      chk("fall_bit0", rd[1], 32'h01);
      wr(2'd3, 32'hFF);
      in_port = 8'h81;
      repeat (LAT) tick();
      wr(2'd3, 32'h01);
      rd_addr(2'd3);
      chk("collide_cap_rise", rd[0], 32'h01);
      chk("collide_cap_any", rd[2], 32'h01);

      // Counter clear colliding with a change
      in_port = 8'h01;
      repeat (LAT) tick();
      wr(2'd1, 32'h0);
      rd_addr(2'd1);
      chk("collide_cnt", rd[0], 32'h1);

      // Falling mode 1->0
      wr(2'd3, 32'hFF);
      in_port = 8'h00;
      repeat (LAT + 2) tick();
      rd_addr(2'd3);
      chk("fall_mode", rd[1], 32'h01);
      chk("fall_mode_rise_none", rd[0], 32'h00);

      // Any-edge mode: both directions on bit 1
      wr(2'd3, 32'hFF);
      in_port = 8'h02;
      repeat (LAT + 2) tick();
      rd_addr(2'd3);
      chk("any_up", rd[2], 32'h02);
      wr(2'd3, 32'h02);
      in_port = 8'h00;
      repeat (LAT + 2) tick();
      rd_addr(2'd3);
      chk("any_down", rd[2], 32'h02);
      chk("any_down_rise_none", rd[0], 32'h00);

      // Counter wrap: 17 changes on a 4-bit counter
      wr(2'd1, 32'h0);
      for (int i = 0; i < 17; i++) begin
         in_port = in_port ^ 8'h10;
         tick(); tick();
      end
      repeat (LAT + 1) tick();
      rd_addr(2'd1);
      chk("cnt_wrap", rd[0], 32'h1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
         address = 2'($urandom_range(0, 3));
         cs      = 1'($urandom);
         wn      = ($urandom_range(0, 5) != 0);
         wdata   = $urandom;
         tick();
      end
      cs = 1'b0; wn = 1'b1;

      // Mid-operation reset with irq=1 and CHGCNT=5
      in_port = 8'h00;
      repeat (LAT + 2) tick();
      wr(2'd2, 32'h01);
      wr(2'd3, 32'hFF);
      wr(2'd1, 32'h0);
      for (int i = 0; i < 5; i++) begin
         in_port = in_port ^ 8'h01;
         tick(); tick();
      end
      repeat (LAT + 1) tick();
      rd_addr(2'd1);
      chk("pre_reset_cnt", rd[0], 32'h5);
      chk("pre_reset_irq", 32'(irq[0]), 32'h1);
      in_port = 8'h00;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int e = 0; e < 3; e++) begin
         chk($sformatf("async_rst_irq[%0d]", e), 32'(irq[e]), 32'h0);
         chk($sformatf("async_rst_rd[%0d]", e), rd[e], 32'h0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rd_addr(2'd1);
      chk("post_reset_cnt", rd[0], 32'h0);
      rd_addr(2'd3);
      chk("post_reset_cap", rd[0], 32'h0);
      chk("post_reset_irq", 32'(irq[0]), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
